uart_pkt_parser: RTL

Framing stage directly downstream of the UART byte receiver. Consumes its byte output (`rx_data`, `rx_status`) and assembles bytes into length-prefixed, checksummed packets. Valid packets are held in an internal buffer and offered to the host logic through a valid/ack handshake with random-access payload read. Malformed, timed-out and overrun traffic is reported on single-cycle error pulses.

---
 rtl/uart_pkt_parser.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: assembles receiver bytes into SYNC/LEN/payload/CHK packets,
// holds a checked packet for the host and flags malformed, stalled or overrun traffic.
module uart_pkt_parser #(
  parameter int          MAXLEN  = 16,
  parameter int          TIMEOUT = 4096,
  parameter logic [7:0]  SYNC    = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_status,
  output logic       pkt_valid,
  output logic [7:0] pkt_len,
  input  logic [7:0] pkt_addr,
  output logic [7:0] pkt_rdata,
  input  logic       pkt_ack,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_tmo,
  output logic       err_ovr
);

  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

  state_t        state_q;
  logic          rsDly_q;
  logic [7:0]    len_q;
  logic [7:0]    sum_q;
  logic [7:0]    idx_q;
  logic [TW-1:0] tmoCnt_q;
  logic          pktValid_q;
  logic          errChk_q;
  logic          errLen_q;
  logic          errTmo_q;
  logic          errOvr_q;
  logic [7:0]    bufMem [MAXLEN];

  logic stb;
  logic midFrame;
  logic tmoHit;
  logic bufWe;

  // A byte arrives on the rising edge of the receiver's stop-bit-valid flag.
  assign stb      = rx_status & ~rsDly_q;
  assign midFrame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign tmoHit   = (tmoCnt_q == TW'(TIMEOUT - 1));
  assign bufWe    = stb && (state_q == PAYLOAD);

  // Edge detector for rx_status; starts high so a flag already up at reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsDly_q <= 1'b1;
    else     rsDly_q <= rx_status;
  end

  // Payload storage; contents are only meaningful once a packet has been checked.
  always_ff @(posedge clk) begin
    if (bufWe) bufMem[idx_q[AW-1:0]] <= rx_data;
  end

  // Framing FSM with inter-byte timeout and registered status/error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      tmoCnt_q   <= '0;
      pktValid_q <= 1'b0;
      errChk_q   <= 1'b0;
      errLen_q   <= 1'b0;
      errTmo_q   <= 1'b0;
      errOvr_q   <= 1'b0;
    end else begin
      errChk_q <= 1'b0;
      errLen_q <= 1'b0;
      errTmo_q <= 1'b0;
      errOvr_q <= 1'b0;

      if (stb) begin
        tmoCnt_q <= '0;
      end else if (midFrame) begin
        if (tmoHit) begin
          errTmo_q <= 1'b1;
          tmoCnt_q <= '0;
          state_q  <= IDLE;
        end else begin
          tmoCnt_q <= tmoCnt_q + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (stb && rx_data == SYNC) state_q <= LEN;
        end
        LEN: begin
          if (stb) begin
            if (rx_data != 8'd0 && rx_data <= 8'(MAXLEN)) begin
              len_q   <= rx_data;
              sum_q   <= rx_data;
              idx_q   <= '0;
              state_q <= PAYLOAD;
            end else begin
              errLen_q <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        PAYLOAD: begin
          if (stb) begin
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= CHK;
          end
        end
        CHK: begin
          if (stb) begin
            if (rx_data == sum_q) begin
              pktValid_q <= 1'b1;
              state_q    <= HOLD;
            end else begin
              errChk_q <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        HOLD: begin
          if (stb) errOvr_q <= 1'b1;
          if (pkt_ack) begin
            pktValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pkt_valid = pktValid_q;
  assign pkt_len   = len_q;
  assign pkt_rdata = (pkt_addr < len_q) ? bufMem[pkt_addr[AW-1:0]] : 8'h00;
  assign err_chk   = errChk_q;
  assign err_len   = errLen_q;
  assign err_tmo   = errTmo_q;
  assign err_ovr   = errOvr_q;

endmodule
